// File: rtl/rv8_pkg.sv
// Shared opcode constants, field widths and hazard FSM state encoding for the
// 8-bit RISC-V pipeline control blocks.
package rv8_pkg;

  localparam int INSTR_W = 32;
  localparam int OPC_W   = 7;
  localparam int REG_W   = 5;

  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    HZ_INIT     = 2'd0,
    HZ_RUN      = 2'd1,
    HZ_FLUSH    = 2'd2,
    HZ_MEM_WAIT = 2'd3
  } hz_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use detector: decodes the ID instruction's source usage
// and compares it against the EX-stage shadow. Reusable by the forwarding unit.
module hazard_detect
  import rv8_pkg::*;
(
  input  logic [INSTR_W-1:0] id_instr,
  input  logic               id_valid,
  input  logic               ex_valid,
  input  logic               ex_is_load,
  input  logic [REG_W-1:0]   ex_rd,
  output logic               load_use,
  output logic               uses_rs2,
  output logic               is_load
);

  logic [OPC_W-1:0] opcode;
  logic [REG_W-1:0] rs1;
  logic [REG_W-1:0] rs2;
  logic             uses_rs1;
  logic             unused_fields;

  assign opcode = id_instr[6:0];
  assign rs1    = id_instr[19:15];
  assign rs2    = id_instr[24:20];

  // funct7/funct3 and rd do not affect source-register usage
  assign unused_fields = &{1'b0, id_instr[31:25], id_instr[14:7]};

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    is_load  = 1'b0;
    case (opcode)
      OPC_LOAD:   begin uses_rs1 = 1'b1; is_load = 1'b1; end
      OPC_OPIMM:  uses_rs1 = 1'b1;
      OPC_STORE,
      OPC_OP,
      OPC_BRANCH: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      default:    ;
    endcase
  end

  assign load_use = id_valid & ex_valid & ex_is_load & (ex_rd != '0) &
                    ((uses_rs1 & (ex_rd == rs1)) | (uses_rs2 & (ex_rd == rs2)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch
// flushes and data-memory wait stalls. Optional counters: HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import rv8_pkg::*;
#(
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] id_instr,
  input  logic               id_valid,
  input  logic               ex_branch_taken,
  input  logic               mem_req,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               ifid_flush,
  output logic               idex_write,
  output logic               idex_flush,
  output logic               exmem_write,
  output logic               memwb_write,
  output logic [1:0]         ctrl_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [CNT_W-1:0]   flush_cycles
`endif
);

  localparam logic [1:0] FCNT_LOAD = 2'(FLUSH_DEPTH - 1);

  if (FLUSH_DEPTH < 1 || FLUSH_DEPTH > 3 || CNT_W < 1) begin : g_param_check
    $error("pipeline_hazard_ctrl: FLUSH_DEPTH must be 1..3 and CNT_W >= 1");
  end

  hz_state_t        state_reg, state_next;
  logic [1:0]       fcnt_reg, fcnt_next;
  logic             ex_valid_reg;
  logic             ex_is_load_reg;
  logic [REG_W-1:0] ex_rd_reg;

  logic             load_use;
  logic             id_is_load;
  logic             unused_id_uses_rs2;
  logic             mem_stall;
  logic             run_eval;
  logic             flush_eval;
  logic             stall_evt;

  hazard_detect u_hazard_detect (
    .id_instr   (id_instr),
    .id_valid   (id_valid),
    .ex_valid   (ex_valid_reg),
    .ex_is_load (ex_is_load_reg),
    .ex_rd      (ex_rd_reg),
    .load_use   (load_use),
    .uses_rs2   (unused_id_uses_rs2),
    .is_load    (id_is_load)
  );

  assign mem_stall  = mem_req & ~mem_ready;
  assign ctrl_state = state_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= HZ_INIT;
      fcnt_reg  <= 2'd0;
    end else begin
      state_reg <= state_next;
      fcnt_reg  <= fcnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    fcnt_next   = fcnt_reg;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_write  = 1'b0;
    idex_flush  = 1'b0;
    exmem_write = 1'b0;
    memwb_write = 1'b0;
    run_eval    = 1'b0;
    flush_eval  = 1'b0;
    stall_evt   = 1'b0;

    // Pick which rule set applies this cycle; a wait-exit cycle skips the stall check
    case (state_reg)
      HZ_INIT: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        state_next = HZ_RUN;
      end
      HZ_RUN: begin
        if (mem_stall) state_next = HZ_MEM_WAIT;
        else           run_eval   = 1'b1;
      end
      HZ_FLUSH: begin
        if (mem_stall) state_next = HZ_MEM_WAIT;
        else           flush_eval = 1'b1;
      end
      HZ_MEM_WAIT: begin
        if (mem_ready) begin
          if (fcnt_reg != 2'd0) flush_eval = 1'b1;
          else                  run_eval   = 1'b1;
        end
      end
      default: state_next = HZ_INIT;
    endcase

    if (flush_eval) begin
      {pc_write, ifid_write, ifid_flush, idex_write, idex_flush} = 5'b11111;
      {exmem_write, memwb_write} = 2'b11;
      fcnt_next  = fcnt_reg - 2'd1;
      state_next = (fcnt_reg == 2'd1) ? HZ_RUN : HZ_FLUSH;
    end else if (run_eval) begin
      state_next = HZ_RUN;
      if (ex_branch_taken) begin
        {pc_write, ifid_write, ifid_flush, idex_write, idex_flush} = 5'b11111;
        {exmem_write, memwb_write} = 2'b11;
        fcnt_next  = FCNT_LOAD;
        state_next = (FLUSH_DEPTH > 1) ? HZ_FLUSH : HZ_RUN;
      end else if (load_use) begin
        idex_write  = 1'b1;
        idex_flush  = 1'b1;
        exmem_write = 1'b1;
        memwb_write = 1'b1;
        stall_evt   = 1'b1;
      end else begin
        {pc_write, ifid_write, idex_write, exmem_write, memwb_write} = 5'b11111;
      end
    end
  end

  // The bubble inserted on a load-use clears ex_valid, so the stall lasts one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_reg   <= 1'b0;
      ex_is_load_reg <= 1'b0;
      ex_rd_reg      <= '0;
    end else if (idex_write) begin
      if (idex_flush || load_use || !id_valid) begin
        ex_valid_reg <= 1'b0;
      end else begin
        ex_valid_reg   <= 1'b1;
        ex_is_load_reg <= id_is_load;
        ex_rd_reg      <= id_instr[11:7];
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if ((stall_evt || state_reg == HZ_MEM_WAIT) && stall_cnt_reg != '1)
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (ifid_flush && state_reg != HZ_INIT && flush_cnt_reg != '1)
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign stall_cycles = stall_cnt_reg;
  assign flush_cycles = flush_cnt_reg;
`else
  logic unused_stall_evt;
  assign unused_stall_evt = stall_evt;
`endif

endmodule
